// File: rtl/adc_spi_reader.sv
// adc_spi_reader: front-end source for the CNN datapath.
// A free-running timer starts a conversion on an external serial ADC every
// SAMPLE_PERIOD clocks. The result is shifted in MSB first over CONVST/SCK/SDO
// and offered on a single-entry valid/ready output register.
// Optional feature macro: ADC_SPI_READER_OVERRUN_EN adds adc_reader_overrun_cnt,
// a saturating count of dropped samples.
module adc_spi_reader #(
    parameter int ADC_WIDTH     = 12,
    parameter int SAMPLE_PERIOD = 250,
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int SCK_DIV       = 2,
    parameter int OVR_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 adc_convst,
    output logic                 adc_sck,
    input  logic                 adc_sdo,
    input  logic                 adc_reader_ready_out,
    output logic                 adc_reader_valid_out,
    output logic [ADC_WIDTH-1:0] adc_reader_data_out,
    output logic                 adc_reader_busy
`ifdef ADC_SPI_READER_OVERRUN_EN
    ,
    output logic [OVR_WIDTH-1:0] adc_reader_overrun_cnt
`endif
);

    localparam int TMR_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int PH_MAX = (CONV_CYCLES > CONVST_CYCLES) ? CONV_CYCLES : CONVST_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int DIV_W  = $clog2(SCK_DIV + 1);
    localparam int BIT_W  = $clog2(ADC_WIDTH + 1);

    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [PH_W-1:0]  CONVST_LAST = PH_W'(CONVST_CYCLES - 1);
    localparam logic [PH_W-1:0]  CONV_LAST   = PH_W'(CONV_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(ADC_WIDTH - 1);

    // Half-period divider and counter widths assume at least one clock / bit.
    if (SCK_DIV < 1 || OVR_WIDTH < 1) begin : g_bad_param
        $error("adc_spi_reader: SCK_DIV and OVR_WIDTH must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVST,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [TMR_W-1:0]       timer_reg;
    logic                   tick;
    logic [PH_W-1:0]        phase_reg;
    logic [DIV_W-1:0]       div_reg;
    logic [BIT_W-1:0]       bit_reg;
    logic                   sck_reg;
    logic                   convst_reg;
    logic [ADC_WIDTH-1:0]   shift_reg;
    logic                   valid_reg;
    logic [ADC_WIDTH-1:0]   data_reg;
    logic                   div_last;
    logic                   shift_done;
    logic                   load;

    assign tick       = enable && (timer_reg == TMR_LAST);
    assign div_last   = (div_reg == DIV_LAST);
    assign shift_done = (state_reg == S_SHIFT) && div_last && sck_reg && (bit_reg == BIT_LAST);
    // The output register accepts a new sample when empty or draining this cycle.
    assign load       = (state_reg == S_DONE) && (!valid_reg || adc_reader_ready_out);

    // Sample-period timer; held at zero while sampling is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_reg <= '0;
        end else if (!enable || timer_reg == TMR_LAST) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + TMR_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; only IDLE reacts to a tick.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (tick) state_next = S_CONVST;
            S_CONVST: if (phase_reg == CONVST_LAST) state_next = S_WAIT;
            S_WAIT:   if (phase_reg == CONV_LAST) state_next = S_SHIFT;
            S_SHIFT:  if (shift_done) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Clocks spent in CONVST/WAIT; restarts on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg <= '0;
        end else if (state_next != state_reg) begin
            phase_reg <= '0;
        end else if (state_reg == S_CONVST || state_reg == S_WAIT) begin
            phase_reg <= phase_reg + PH_W'(1);
        end
    end

    // CONVST strobe registered from the next state so it is glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            convst_reg <= 1'b0;
        end else begin
            convst_reg <= (state_next == S_CONVST);
        end
    end

    // SCK generation and MSB-first capture on the clock where SCK rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg   <= '0;
            bit_reg   <= '0;
            sck_reg   <= 1'b0;
            shift_reg <= '0;
        end else if (state_reg != S_SHIFT) begin
            div_reg <= '0;
            bit_reg <= '0;
            sck_reg <= 1'b0;
        end else if (div_last) begin
            div_reg <= '0;
            if (!sck_reg) begin
                sck_reg   <= 1'b1;
                shift_reg <= {shift_reg[ADC_WIDTH-2:0], adc_sdo};
            end else begin
                sck_reg <= 1'b0;
                bit_reg <= bit_reg + BIT_W'(1);
            end
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    // Single-entry output register; held stable under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= shift_reg;
        end else if (valid_reg && adc_reader_ready_out) begin
            valid_reg <= 1'b0;
        end
    end

`ifdef ADC_SPI_READER_OVERRUN_EN
    logic [OVR_WIDTH-1:0] ovr_reg;
    logic [1:0]           ovr_inc;
    logic [OVR_WIDTH:0]   ovr_sum;

    // A tick outside IDLE and a DONE-cycle discard each count as one drop.
    assign ovr_inc = {1'b0, tick && (state_reg != S_IDLE)}
                   + {1'b0, (state_reg == S_DONE) && !load};
    assign ovr_sum = {1'b0, ovr_reg} + (OVR_WIDTH + 1)'(ovr_inc);

    // Saturating overrun counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_reg <= '0;
        end else if (ovr_sum[OVR_WIDTH]) begin
            ovr_reg <= '1;
        end else begin
            ovr_reg <= ovr_sum[OVR_WIDTH-1:0];
        end
    end

    assign adc_reader_overrun_cnt = ovr_reg;
`endif

    assign adc_convst           = convst_reg;
    assign adc_sck              = sck_reg;
    assign adc_reader_valid_out = valid_reg;
    assign adc_reader_data_out  = data_reg;
    assign adc_reader_busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed testbench for adc_spi_reader: a default instance driven by a
// behavioural serial ADC model, plus a SAMPLE_PERIOD=100 instance whose
// ADC data line is tied high.
module tb_adc_spi_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        ready = 1'b1;
    logic        en2 = 1'b0;
    logic        adc_convst, adc_sck, adc_sdo, valid, busy;
    logic [11:0] data;
    logic        convst2, sck2, valid2, busy2;
    logic [11:0] data2;
`ifdef ADC_SPI_READER_OVERRUN_EN
    logic [15:0] ovr, ovr2;
`endif

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_spi_reader dut (
        .clk                   (clk),
        .rst                   (rst),
        .enable                (enable),
        .adc_convst            (adc_convst),
        .adc_sck               (adc_sck),
        .adc_sdo               (adc_sdo),
        .adc_reader_ready_out  (ready),
        .adc_reader_valid_out  (valid),
        .adc_reader_data_out   (data),
        .adc_reader_busy       (busy)
`ifdef ADC_SPI_READER_OVERRUN_EN
        ,
        .adc_reader_overrun_cnt(ovr)
`endif
    );

    adc_spi_reader #(.SAMPLE_PERIOD(100)) dut2 (
        .clk                   (clk),
        .rst                   (rst),
        .enable                (en2),
        .adc_convst            (convst2),
        .adc_sck               (sck2),
        .adc_sdo               (1'b1),
        .adc_reader_ready_out  (1'b1),
        .adc_reader_valid_out  (valid2),
        .adc_reader_data_out   (data2),
        .adc_reader_busy       (busy2)
`ifdef ADC_SPI_READER_OVERRUN_EN
        ,
        .adc_reader_overrun_cnt(ovr2)
`endif
    );

    // ADC model: loads the next queued value on CONVST, shifts after each SCK fall.
    logic [11:0] adc_q[$];
    logic [11:0] adc_shift = 12'h000;
    assign adc_sdo = adc_shift[11];
    always @(posedge adc_convst or negedge adc_sck) begin
        if (adc_convst) begin
            if (adc_q.size() > 0) adc_shift = adc_q.pop_front();
            else adc_shift = 12'hA5C;
        end else begin
            adc_shift = {adc_shift[10:0], 1'b0};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_convst(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            if (adc_convst) begin t = cyc; return; end
            step();
        end
    endtask

    task automatic wait_valid(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            if (valid) begin t = cyc; return; end
            step();
        end
    endtask

    task automatic wait_valid2(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            if (valid2) begin t = cyc; return; end
            step();
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (adc_convst !== 1'b0) begin errors++; $display("FAIL reset_convst got %b want 0", adc_convst); end
        checks++; if (adc_sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", adc_sck); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (data !== 12'h000) begin errors++; $display("FAIL reset_data got %h want 000", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int c0, tc, tv2, first_v, pat_bad, conv_bad, rises;
        logic [11:0] d_at_v;
        logic sck_h[140];
        logic conv_h[140];
        logic val_h[140];
        logic exp_b;
        c0 = cyc;
        enable = 1'b1;
        en2 = 1'b1;
        wait_convst(400, tc);
        checks++; if (tc < 0 || tc - c0 != 250) begin errors++; $display("FAIL first_tick got %0d want 250", tc - c0); end
        if (tc < 0) return;
        first_v = -1;
        d_at_v = 12'h000;
        for (int k = 0; k < 140; k++) begin
            sck_h[k] = adc_sck; conv_h[k] = adc_convst; val_h[k] = valid;
            if (valid && first_v < 0) begin first_v = k; d_at_v = data; end
            step();
        end
        checks++; if (first_v != 131) begin errors++; $display("FAIL latency got %0d want 131", first_v); end
        checks++; if (d_at_v !== 12'hA5C) begin errors++; $display("FAIL basic_data got %h want a5c", d_at_v); end
        checks++; if (val_h[132] !== 1'b0) begin errors++; $display("FAIL valid_clear got %b want 0", val_h[132]); end
        pat_bad = 0; conv_bad = 0; rises = 0;
        for (int k = 0; k < 140; k++) begin
            exp_b = (k >= 84 && k <= 129 && ((k - 84) % 4) < 2);
            if (sck_h[k] !== exp_b) pat_bad++;
            if (k > 0 && sck_h[k] && !sck_h[k-1]) rises++;
            exp_b = (k < 2);
            if (conv_h[k] !== exp_b) conv_bad++;
        end
        checks++; if (rises != 12) begin errors++; $display("FAIL sck_rises got %0d want 12", rises); end
        checks++; if (pat_bad != 0) begin errors++; $display("FAIL sck_pattern got %0d bad cycles want 0", pat_bad); end
        checks++; if (conv_bad != 0) begin errors++; $display("FAIL convst_width got %0d bad cycles want 0", conv_bad); end
        wait_valid(300, tv2);
        checks++; if (tv2 < 0 || tv2 - (tc + first_v) != 250) begin errors++; $display("FAIL period got %0d want 250", tv2 - (tc + first_v)); end
    endtask

    task automatic test_sp100();
        int t1, t2, t3, conv_n, sck_n;
`ifdef ADC_SPI_READER_OVERRUN_EN
        logic [15:0] o1;
`endif
        wait_valid2(400, t1);
        checks++; if (t1 < 0) begin errors++; $display("FAIL sp100_first got timeout want valid"); end
        if (t1 < 0) return;
`ifdef ADC_SPI_READER_OVERRUN_EN
        o1 = ovr2;
`endif
        step();
        conv_n = 0; sck_n = 0; t2 = -1;
        for (int i = 0; i < 300; i++) begin
            if (valid2) begin t2 = cyc; break; end
            if (convst2) conv_n++;
            if (sck2) sck_n++;
            step();
        end
        checks++; if (t2 < 0 || t2 - t1 != 200) begin errors++; $display("FAIL sp100_interval got %0d want 200", t2 - t1); end
        checks++; if (data2 !== 12'hFFF) begin errors++; $display("FAIL sp100_data got %h want fff", data2); end
        checks++; if (conv_n != 2) begin errors++; $display("FAIL sp100_convst got %0d want 2", conv_n); end
        checks++; if (sck_n != 24) begin errors++; $display("FAIL sp100_sck got %0d want 24", sck_n); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL sp100_busy got %b want 0", busy2); end
`ifdef ADC_SPI_READER_OVERRUN_EN
        checks++; if (ovr2 - o1 != 16'd1) begin errors++; $display("FAIL sp100_ovr got %0d want 1", ovr2 - o1); end
`endif
        step();
        wait_valid2(300, t3);
        checks++; if (t3 < 0 || t3 - t2 != 200) begin errors++; $display("FAIL sp100_interval2 got %0d want 200", t3 - t2); end
    endtask

    task automatic test_backpressure();
        int t, bad;
        logic seen;
`ifdef ADC_SPI_READER_OVERRUN_EN
        logic [15:0] o0;
`endif
        wait_valid(300, t);
        step();
        ready = 1'b0;
        adc_q.push_back(12'h001); adc_q.push_back(12'h002);
        adc_q.push_back(12'h003); adc_q.push_back(12'h004);
`ifdef ADC_SPI_READER_OVERRUN_EN
        o0 = ovr;
`endif
        seen = 1'b0; bad = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (valid) seen = 1'b1;
            if (seen && (valid !== 1'b1 || data !== 12'h001)) bad++;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_seen got %b want 1", seen); end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
        checks++; if (data !== 12'h001) begin errors++; $display("FAIL bp_data got %h want 001", data); end
`ifdef ADC_SPI_READER_OVERRUN_EN
        checks++; if (ovr - o0 != 16'd2) begin errors++; $display("FAIL bp_ovr got %0d want 2", ovr - o0); end
`endif
        ready = 1'b1;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", valid); end
        wait_valid(400, t);
        checks++; if (t < 0 || data !== 12'h004) begin errors++; $display("FAIL bp_next got %h want 004", data); end
    endtask

    task automatic test_enable_off();
        int tc, tv, conv_n, busy_n;
        wait_convst(300, tc);
        checks++; if (tc < 0) begin errors++; $display("FAIL en_tick got timeout want convst"); end
        if (tc < 0) return;
        repeat (9) step();
        enable = 1'b0;
        wait_valid(200, tv);
        checks++; if (tv < 0 || data !== 12'hA5C) begin errors++; $display("FAIL en_data got %h want a5c", data); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_busy got %b want 0", busy); end
        conv_n = 0; busy_n = 0;
        for (int i = 0; i < 600; i++) begin
            if (adc_convst) conv_n++;
            if (busy) busy_n++;
            step();
        end
        checks++; if (conv_n != 0) begin errors++; $display("FAIL en_no_convst got %0d want 0", conv_n); end
        checks++; if (busy_n != 0) begin errors++; $display("FAIL en_idle got %0d busy cycles want 0", busy_n); end
    endtask

    task automatic test_reset_mid_shift();
        int c0, c1, tc, tv;
        adc_q.push_back(12'h777);
        adc_q.push_back(12'h3C6);
        c0 = cyc;
        enable = 1'b1;
        wait_convst(400, tc);
        checks++; if (tc < 0 || tc - c0 != 250) begin errors++; $display("FAIL rst_tick got %0d want 250", tc - c0); end
        if (tc < 0) return;
        repeat (104) step();
        checks++; if (adc_sck !== 1'b1) begin errors++; $display("FAIL rst_sck_pre got %b want 1", adc_sck); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (adc_sck !== 1'b0) begin errors++; $display("FAIL rst_async_sck got %b want 0", adc_sck); end
        checks++; if (adc_convst !== 1'b0) begin errors++; $display("FAIL rst_async_convst got %b want 0", adc_convst); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", valid); end
        checks++; if (data !== 12'h000) begin errors++; $display("FAIL rst_async_data got %h want 000", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy got %b want 0", busy); end
        repeat (2) step();
        rst = 1'b1;
        c1 = cyc;
        wait_convst(400, tc);
        checks++; if (tc < 0 || tc - c1 != 250) begin errors++; $display("FAIL rst_next_tick got %0d want 250", tc - c1); end
        if (tc < 0) return;
        wait_valid(200, tv);
        checks++; if (tv < 0 || tv - tc != 131) begin errors++; $display("FAIL rst_latency got %0d want 131", tv - tc); end
        checks++; if (data !== 12'h3C6) begin errors++; $display("FAIL rst_data got %h want 3c6", data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sp100();
        test_backpressure();
        test_enable_off();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
